// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read slave port (AR + R) between
// NUM_M read masters. One burst is in flight at a time; the grant is held
// from the AR issue until the rlast beat handshakes.
module axi_rd_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int SIZE_W = 3,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_M*ADDR_W-1:0]   m_araddr,
  input  logic [NUM_M*LEN_W-1:0]    m_arlen,
  input  logic [NUM_M*SIZE_W-1:0]   m_arsize,
  input  logic [NUM_M*2-1:0]        m_arburst,
  input  logic [NUM_M-1:0]          m_arvalid,
  output logic [NUM_M-1:0]          m_arready,
  output logic [NUM_M-1:0]          m_rvalid,
  input  logic [NUM_M-1:0]          m_rready,
  output logic                      m_rlast,
  output logic [1:0]                m_rresp,
  output logic [DATA_W-1:0]         m_rdata,
  output logic [ADDR_W-1:0]         s_araddr,
  output logic [LEN_W-1:0]          s_arlen,
  output logic [SIZE_W-1:0]         s_arsize,
  output logic [1:0]                s_arburst,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  input  logic                      s_rvalid,
  input  logic                      s_rlast,
  input  logic [1:0]                s_rresp,
  input  logic [DATA_W-1:0]         s_rdata,
  output logic                      s_rready,
  output logic [((NUM_M > 1) ? $clog2(NUM_M) : 1)-1:0] grant,
  output logic                      busy
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AR   = 2'd1,
    ARB_R    = 2'd2
  } arb_state_t;

  arb_state_t       state_r, state_s;
  logic [IDX_W-1:0] grant_r, grant_s;
  logic [IDX_W-1:0] last_grant_r, last_grant_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_found_s;

  // Round-robin search: first requester after last_grant, wrapping modulo NUM_M.
  always_comb begin
    pick_idx_s   = grant_r;
    pick_found_s = 1'b0;
    for (int i = 1; i <= NUM_M; i++) begin
      if (!pick_found_s && m_arvalid[(int'(last_grant_r) + i) % NUM_M]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IDX_W'((int'(last_grant_r) + i) % NUM_M);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state logic: pick in IDLE, hold through AR handshake and R burst.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_found_s) begin
          grant_s = pick_idx_s;
          state_s = ARB_AR;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_AR: begin
        if (!m_arvalid[grant_r]) begin
          // Master withdrew its request: rearbitrate without moving the pointer.
          state_s = ARB_IDLE;
        end else if (s_arready) begin
          last_grant_s = grant_r;
          state_s      = ARB_R;
        end else begin
          state_s = ARB_AR;
        end
      end
      ARB_R: begin
        if (s_rvalid && m_rready[grant_r] && s_rlast) begin
          state_s = ARB_IDLE;
        end else begin
          state_s = ARB_R;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ARB_IDLE;
      grant_r      <= {IDX_W{1'b0}};
      last_grant_r <= IDX_W'(NUM_M - 1);
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
    end
  end

  // Handshake routing; everything is quiet in IDLE and while reset is held.
  always_comb begin
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = {NUM_M{1'b0}};
    m_rvalid  = {NUM_M{1'b0}};
    busy      = 1'b0;
    if (!reset) begin
      case (state_r)
        ARB_AR: begin
          busy               = 1'b1;
          s_arvalid          = m_arvalid[grant_r];
          m_arready[grant_r] = s_arready;
        end
        ARB_R: begin
          busy              = 1'b1;
          m_rvalid[grant_r] = s_rvalid;
          s_rready          = m_rready[grant_r];
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end else begin
      busy = 1'b0;
    end
  end

  // Payload always follows the granted master; R payload is broadcast.
  assign s_araddr  = m_araddr[int'(grant_r) * ADDR_W +: ADDR_W];
  assign s_arlen   = m_arlen[int'(grant_r) * LEN_W +: LEN_W];
  assign s_arsize  = m_arsize[int'(grant_r) * SIZE_W +: SIZE_W];
  assign s_arburst = m_arburst[int'(grant_r) * 2 +: 2];
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;
  assign grant     = grant_r;

endmodule
